// File: rtl/morse_keying_classifier.sv
// Turns the debounced key level into one-cycle dot/dash/letter-gap/word-gap events.
// Press and gap lengths are measured in units of UNIT_CYCLES clocks, starting at each key edge.
module morse_keying_classifier #(
   parameter int UNIT_CYCLES = 5_000_000,
   parameter int DASH_UNITS  = 2,
   parameter int LG_UNITS    = 3,
   parameter int WG_UNITS    = 7
) (
   input  logic clk,
   input  logic reset_n,
   input  logic b,
   output logic dot,
   output logic dash,
   output logic lg,
   output logic wg,
   output logic busy
);
   localparam int PW = $clog2(UNIT_CYCLES);
   localparam logic [PW-1:0] PRESC_MAX = PW'(UNIT_CYCLES - 1);
   localparam logic [3:0] DASH_U = 4'(DASH_UNITS);
   localparam logic [3:0] LG_U   = 4'(LG_UNITS);
   localparam logic [3:0] WG_U   = 4'(WG_UNITS);

   typedef enum logic [1:0] {IDLE, PRESS, GAP, LETTER} state_t;

   state_t          state, state_d;
   logic            b_q, armed;
   logic [PW-1:0]   presc;
   logic [3:0]      units, units_inc;
   logic            edge_ev, rise, fall, tick;
   logic            dot_d, dash_d, lg_d, wg_d;

   // After reset the key must be seen released before a rise counts, so a press
   // already in progress across reset can never produce a symbol.
   assign edge_ev   = b ^ b_q;
   assign rise      = b & ~b_q & armed;
   assign fall      = ~b & b_q;
   assign tick      = (presc == PRESC_MAX) & ~edge_ev;
   assign units_inc = (units == 4'd15) ? 4'd15 : units + 4'd1;
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         b_q   <= 1'b0;
         armed <= 1'b0;
         presc <= '0;
         units <= '0;
      end else begin
         b_q   <= b;
         armed <= armed | ~b;
         if (edge_ev) begin
            presc <= '0;
            units <= '0;
         end else if (tick) begin
            presc <= '0;
            units <= units_inc;
         end else begin
            presc <= presc + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state;
      dot_d   = 1'b0;
      dash_d  = 1'b0;
      lg_d    = 1'b0;
      wg_d    = 1'b0;
      case (state)
         IDLE:  if (rise) state_d = PRESS;
         PRESS: if (fall) begin
            if (units >= DASH_U) dash_d = 1'b1;
            else                 dot_d  = 1'b1;
            state_d = GAP;
         end
         // A rise on the threshold tick wins: no gap event, back to counting a press.
         GAP: begin
            if (rise) state_d = PRESS;
            else if (tick && units_inc == LG_U) begin
               lg_d    = 1'b1;
               state_d = LETTER;
            end
         end
         LETTER: begin
            if (rise) state_d = PRESS;
            else if (tick && units_inc == WG_U) begin
               wg_d    = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         dot   <= 1'b0;
         dash  <= 1'b0;
         lg    <= 1'b0;
         wg    <= 1'b0;
      end else begin
         state <= state_d;
         dot   <= dot_d;
         dash  <= dash_d;
         lg    <= lg_d;
         wg    <= wg_d;
      end
   end
endmodule

// File: tb/tb_morse_keying_classifier.sv
// Bench for morse_keying_classifier: table of press/release patterns with pulse counts,
// hand-written corner sequences and random keying against an edge-distance reference model.
module tb_morse_keying_classifier;
   localparam int U  = 10;
   localparam int DU = 2;
   localparam int LU = 3;
   localparam int WU = 7;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic b = 1'b0;
   logic dot, dash, lg, wg, busy;

   int errors = 0;
   int checks = 0;

   morse_keying_classifier #(.UNIT_CYCLES(U), .DASH_UNITS(DU), .LG_UNITS(LU), .WG_UNITS(WU)) dut (
      .clk(clk), .reset_n(reset_n), .b(b),
      .dot(dot), .dash(dash), .lg(lg), .wg(wg), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: symbols from press length, gap events from distance to the last fall.
   int  cyc = 0;
   int  m_rise, m_fall, t_sym;
   bit  m_press, m_gap, m_armed, m_pb;
   logic [4:0] exp_v;
   int  n_dot, n_dash, n_lg, n_wg;

   task automatic model_reset();
      m_press = 0; m_gap = 0; m_armed = 0; m_pb = 0;
   endtask

   task automatic model_edge(input logic bv);
      int len, u, d;
      exp_v = '0;
      if (m_armed && bv && !m_pb) begin
         m_press = 1; m_gap = 0; m_rise = cyc;
      end else if (m_press && !bv && m_pb) begin
         len = cyc - m_rise;
         u = (len - 1) / U;
         if (u > 15) u = 15;
         if (u >= DU) exp_v[3] = 1'b1; else exp_v[4] = 1'b1;
         m_press = 0; m_gap = 1; m_fall = cyc;
      end else if (m_gap) begin
         d = cyc - m_fall;
         if (d == LU * U) exp_v[2] = 1'b1;
         if (d == WU * U) begin exp_v[1] = 1'b1; m_gap = 0; end
      end
      if (!bv) m_armed = 1;
      m_pb = bv;
      exp_v[0] = m_press | m_gap;
   endtask

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic step(input logic bv);
      @(negedge clk);
      b = bv;
      @(posedge clk);
      model_edge(bv);
      #1;
      check("outputs{dot,dash,lg,wg,busy}", int'({dot, dash, lg, wg, busy}), int'(exp_v));
      if (dot || dash) t_sym = cyc;
      if (lg) check("lg_delay_after_symbol", cyc - t_sym, LU * U);
      if (wg) check("wg_delay_after_symbol", cyc - t_sym, WU * U);
      n_dot += int'(dot); n_dash += int'(dash); n_lg += int'(lg); n_wg += int'(wg);
      cyc++;
   endtask

   task automatic clear_counts();
      n_dot = 0; n_dash = 0; n_lg = 0; n_wg = 0;
   endtask

   task automatic run(input int press, input int low);
      for (int i = 0; i < press; i++) step(1'b1);
      for (int i = 0; i < low; i++) step(1'b0);
   endtask

   typedef struct {
      int press, low;
      int e_dot, e_dash, e_lg, e_wg;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{15, 100, 1, 0, 1, 1};
      vecs[1] = '{25, 100, 0, 1, 1, 1};
      vecs[2] = '{19, 100, 1, 0, 1, 1};
      vecs[3] = '{200, 100, 0, 1, 1, 1};
      vecs[4] = '{15, 20, 1, 0, 0, 0};
      vecs[5] = '{25, 100, 0, 1, 1, 1};
      vecs[6] = '{15, 50, 1, 0, 1, 0};
      vecs[7] = '{25, 100, 0, 1, 1, 1};

      model_reset();
      t_sym = 0;
      clear_counts();
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", int'({dot, dash, lg, wg, busy}), 0);
      @(negedge clk);
      reset_n = 1'b1;
      run(0, 5);

      for (int i = 0; i < 8; i++) begin
         clear_counts();
         run(vecs[i].press, vecs[i].low);
         check($sformatf("vec%0d_dot_count", i), n_dot, vecs[i].e_dot);
         check($sformatf("vec%0d_dash_count", i), n_dash, vecs[i].e_dash);
         check($sformatf("vec%0d_lg_count", i), n_lg, vecs[i].e_lg);
         check($sformatf("vec%0d_wg_count", i), n_wg, vecs[i].e_wg);
      end

      // Rise lands on the edge where the gap count would reach LG_UNITS.
      clear_counts();
      run(15, LU * U);
      step(1'b1);
      check("rise_at_lg_no_lg", n_lg, 0);
      check("rise_at_lg_busy", int'(busy), 1);
      run(14, 100);
      check("rise_at_lg_dots", n_dot, 2);
      check("rise_at_lg_final_lg", n_lg, 1);

      // Reset mid-press with the key held: the release must not yield a symbol.
      clear_counts();
      run(15, 0);
      @(negedge clk);
      reset_n = 1'b0;
      b = 1'b1;
      #1;
      check("async_reset_outputs", int'({dot, dash, lg, wg, busy}), 0);
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      run(5, 100);
      check("post_reset_no_pulses", n_dot + n_dash + n_lg + n_wg, 0);
      check("post_reset_idle", int'(busy), 0);
      clear_counts();
      run(15, 100);
      check("post_reset_fresh_dot", n_dot, 1);
      check("post_reset_fresh_wg", n_wg, 1);

      for (int i = 0; i < 300; i++) run($urandom_range(1, 60), $urandom_range(1, 90));
      run(0, 80);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
